// File: rtl/ledstring_rx.sv
// Receiver for the two-wire APA102-style LED string: oversamples led_clk/led_data,
// finds the start frame, decodes pixel words and presents them on a valid/ack port.
module ledstring_rx #(
    parameter int unsigned IDLE_TIMEOUT = 1024,
    parameter int unsigned IDX_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             led_clk,
    input  logic             led_data,
    output logic             framing,
    output logic             se_frame,
    output logic [4:0]       dat_glo,
    output logic [7:0]       dat_red,
    output logic [7:0]       dat_grn,
    output logic [7:0]       dat_blu,
    output logic [IDX_W-1:0] pix_idx,
    output logic             valid,
    input  logic             ack,
    output logic             overrun,
    output logic             frame_err
);

    localparam int unsigned TO_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        GAP  = 2'd1,
        WORD = 2'd2
    } state_t;

    state_t          state;
    logic            clk_s1, clk_s2, clk_s3;
    logic            data_s1, data_s2;
    logic            chk;
    logic            bit_q;
    logic [30:0]     shreg;
    logic [5:0]      bit_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            idx_pend;

    logic            rise_c;
    logic [31:0]     word_c;
    logic            start_c, pix_c, end_c, bad_c, ev_c;

    // Two-flop synchronisers; the third led_clk flop yields the rise pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1  <= 1'b0;
            clk_s2  <= 1'b0;
            clk_s3  <= 1'b0;
            data_s1 <= 1'b0;
            data_s2 <= 1'b0;
            chk     <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            clk_s1  <= led_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= led_data;
            data_s2 <= data_s1;
            chk     <= rise_c;
            if (rise_c) begin
                bit_q <= data_s2;
            end
        end
    end

    assign rise_c = clk_s2 & ~clk_s3;

    // Classify the bit captured last cycle: start, pixel, end or malformed word.
    always_comb begin
        word_c  = {shreg, bit_q};
        start_c = 1'b0;
        pix_c   = 1'b0;
        end_c   = 1'b0;
        bad_c   = 1'b0;
        if (chk) begin
            if (state == HUNT && !bit_q && bit_cnt == 6'd31) begin
                start_c = 1'b1;
            end
            if (state == WORD && bit_cnt == 6'd31) begin
                if (word_c == 32'hFFFF_FFFF) begin
                    end_c = 1'b1;
                end else if (word_c[31:29] == 3'b111) begin
                    pix_c = 1'b1;
                end else begin
                    bad_c = 1'b1;
                end
            end
        end
        ev_c = start_c | pix_c | end_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            shreg     <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            idx_pend  <= 1'b0;
            framing   <= 1'b0;
            se_frame  <= 1'b0;
            dat_glo   <= '0;
            dat_red   <= '0;
            dat_grn   <= '0;
            dat_blu   <= '0;
            pix_idx   <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rise_c) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            // An event may replace the held word only when the consumer takes it this cycle.
            if (ev_c) begin
                if (!valid || ack) begin
                    valid    <= 1'b1;
                    framing  <= ~pix_c;
                    se_frame <= end_c;
                    dat_glo  <= pix_c ? word_c[28:24] : 5'd0;
                    dat_blu  <= pix_c ? word_c[23:16] : 8'd0;
                    dat_grn  <= pix_c ? word_c[15:8]  : 8'd0;
                    dat_red  <= pix_c ? word_c[7:0]   : 8'd0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ack) begin
                valid <= 1'b0;
            end

            if (bad_c) begin
                frame_err <= 1'b1;
            end

            if (chk) begin
                case (state)
                    HUNT: begin
                        if (bit_q) begin
                            bit_cnt <= '0;
                        end else if (start_c) begin
                            bit_cnt  <= '0;
                            state    <= GAP;
                            pix_idx  <= '0;
                            idx_pend <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    GAP: begin
                        if (bit_q) begin
                            shreg   <= 31'd1;
                            bit_cnt <= 6'd1;
                            state   <= WORD;
                            if (idx_pend) begin
                                pix_idx  <= pix_idx + IDX_W'(1);
                                idx_pend <= 1'b0;
                            end
                        end
                    end
                    WORD: begin
                        if (bit_cnt == 6'd31) begin
                            bit_cnt <= '0;
                            if (pix_c) begin
                                state    <= GAP;
                                idx_pend <= 1'b1;
                            end else begin
                                state <= HUNT;
                            end
                        end else begin
                            shreg   <= word_c[30:0];
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end else if (state == WORD && !rise_c && to_cnt == TO_MAX) begin
                frame_err <= 1'b1;
                state     <= HUNT;
                bit_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ledstring_rx.sv
// Bench for ledstring_rx: directed and random string streams checked every cycle
// against a word-level model of decoding, latency and the valid/ack handshake.
module tb_ledstring_rx;

    localparam int unsigned TO    = 1024;
    localparam int unsigned IDX_W = 16;

    localparam int K_START = 0;
    localparam int K_PIX   = 1;
    localparam int K_END   = 2;
    localparam int K_ERR   = 3;
    localparam int K_INC   = 4;

    typedef struct {
        int          t;
        int          kind;
        logic [31:0] w;
    } act_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             led_clk = 1'b0;
    logic             led_data = 1'b0;
    logic             ack = 1'b0;
    logic             framing, se_frame;
    logic [4:0]       dat_glo;
    logic [7:0]       dat_red, dat_grn, dat_blu;
    logic [IDX_W-1:0] pix_idx;
    logic             valid, overrun, frame_err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;
    int ack_mode = 0;
    bit ph_rand  = 1'b0;

    // Model of the presented outputs
    logic             m_valid = 0, m_framing = 0, m_se = 0, m_ovr = 0, m_err = 0;
    logic [4:0]       m_glo = 0;
    logic [7:0]       m_red = 0, m_grn = 0, m_blu = 0;
    logic [IDX_W-1:0] m_idx = 0;
    act_t             aq[$];
    logic [63:0]      acc[$];

    // Stream decoder state (word level)
    int          d_state = 0;
    int          d_zrun  = 0;
    int          d_n     = 0;
    logic [31:0] d_w     = 0;
    bit          d_pend  = 0;
    int          d_last_k = 0;

    ledstring_rx #(.IDLE_TIMEOUT(TO), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .led_clk(led_clk), .led_data(led_data),
        .framing(framing), .se_frame(se_frame), .dat_glo(dat_glo),
        .dat_red(dat_red), .dat_grn(dat_grn), .dat_blu(dat_blu),
        .pix_idx(pix_idx), .valid(valid), .ack(ack),
        .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input logic f, input logic s, input logic [4:0] g,
                                       input logic [7:0] b, input logic [7:0] gr,
                                       input logic [7:0] r, input logic [15:0] i);
        return {17'd0, f, s, g, b, gr, r, i};
    endfunction

    function automatic logic [63:0] acc_at(input int i);
        if (i < acc.size()) return acc[i];
        return '1;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        case (ack_mode)
            0:       ack = 1'b0;
            1:       ack = 1'b1;
            default: ack = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic mload(input logic f, input logic s, input logic [31:0] w, output bit ld);
        if (!m_valid || ack) begin
            m_valid   = 1'b1;
            m_framing = f;
            m_se      = s;
            m_glo     = f ? 5'd0 : w[28:24];
            m_blu     = f ? 8'd0 : w[23:16];
            m_grn     = f ? 8'd0 : w[15:8];
            m_red     = f ? 8'd0 : w[7:0];
            ld = 1'b1;
        end else begin
            m_ovr = 1'b1;
            ld = 1'b0;
        end
    endtask

    // Apply scheduled decoder actions at their output edge and run the handshake.
    always @(posedge clk) begin
        act_t a;
        bit   ld;
        cyc = cyc + 1;
        ld  = 1'b0;
        if (rst) begin
            m_valid = 0; m_framing = 0; m_se = 0; m_ovr = 0; m_err = 0;
            m_glo = 0; m_red = 0; m_grn = 0; m_blu = 0; m_idx = 0;
            aq.delete();
        end else begin
            if (m_valid && ack) acc.push_back(pk(m_framing, m_se, m_glo, m_blu, m_grn, m_red, m_idx));
            while (aq.size() > 0 && aq[0].t < cyc) void'(aq.pop_front());
            if (aq.size() > 0 && aq[0].t == cyc) begin
                a = aq.pop_front();
                case (a.kind)
                    K_START: begin m_idx = 0; mload(1'b1, 1'b0, 32'd0, ld); end
                    K_PIX:   mload(1'b0, 1'b0, a.w, ld);
                    K_END:   mload(1'b1, 1'b1, 32'd0, ld);
                    K_ERR:   m_err = 1'b1;
                    default: m_idx = m_idx + 16'd1;
                endcase
            end
            if (!ld && m_valid && ack) m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_outputs",
                  64'({valid, framing, se_frame, dat_glo, dat_red, dat_grn, dat_blu, pix_idx, overrun, frame_err}),
                  64'({m_valid, m_framing, m_se, m_glo, m_red, m_grn, m_blu, m_idx, m_ovr, m_err}));
        end
    end

    // Word-level decode of one string bit whose rise is first captured at edge k.
    task automatic model_bit(input logic b, input int k);
        act_t a;
        a.t = k + 3;
        a.w = 32'd0;
        a.kind = K_INC;
        d_last_k = k;
        case (d_state)
            0: begin
                d_zrun = b ? 0 : d_zrun + 1;
                if (d_zrun == 32) begin
                    a.kind = K_START; aq.push_back(a);
                    d_state = 1; d_zrun = 0;
                end
            end
            1: begin
                if (b) begin
                    d_state = 2; d_w = 32'd1; d_n = 1;
                    if (d_pend) begin a.kind = K_INC; aq.push_back(a); d_pend = 0; end
                end
            end
            default: begin
                d_w = {d_w[30:0], b};
                d_n++;
                if (d_n == 32) begin
                    a.w = d_w;
                    if (d_w == 32'hFFFF_FFFF) begin
                        a.kind = K_END; d_state = 0; d_zrun = 0;
                    end else if (d_w[31:29] == 3'b111) begin
                        a.kind = K_PIX; d_pend = 1; d_state = 1;
                    end else begin
                        a.kind = K_ERR; d_state = 0; d_zrun = 0;
                    end
                    aq.push_back(a);
                end
            end
        endcase
    endtask

    task automatic reset_decoder();
        d_state = 0; d_zrun = 0; d_n = 0; d_w = 0; d_pend = 0;
    endtask

    task automatic send_bit(input logic b);
        int lo, hi;
        lo = ph_rand ? int'($urandom_range(2, 4)) : 2;
        hi = ph_rand ? int'($urandom_range(2, 4)) : 2;
        led_clk  = 1'b0;
        led_data = b;
        repeat (lo) @(negedge clk);
        led_clk = 1'b1;
        model_bit(b, cyc + 1);
        repeat (hi) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic idle(input int n);
        act_t a;
        if (d_state == 2 && cyc + n >= d_last_k + 2 + int'(TO)) begin
            a.t = d_last_k + 2 + int'(TO); a.kind = K_ERR; a.w = 32'd0;
            aq.push_back(a);
            d_state = 0; d_zrun = 0;
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        led_clk = 1'b0;
        rst = 1'b1;
        reset_decoder();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        acc.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        do_reset();
        chk_en = 1'b1;
        check("reset_state", 64'({valid, framing, pix_idx, overrun, frame_err}), 64'd0);

        // Latency at f_clk/4: valid rises exactly 3 edges after capture of the 32nd rise
        ack_mode = 0;
        send_zeros(32);
        @(negedge clk);
        check("lat_k2_valid", 64'(valid), 64'd0);
        @(negedge clk);
        check("lat_k3_valid", 64'(valid), 64'd1);
        check("lat_start_kind", 64'({framing, se_frame}), 64'h2);

        // Start, two pixels, end with ack held high
        do_reset();
        ack_mode = 1;
        send_zeros(32);
        send_word(32'hFFAA55EE);
        send_word(32'hFF9944DD);
        send_word(32'hFFFF_FFFF);
        idle(10);
        check("t1_count", 64'(acc.size()), 64'd4);
        check("t1_start", acc_at(0), pk(1, 0, 5'h00, 8'h00, 8'h00, 8'h00, 16'd0));
        check("t1_pix0",  acc_at(1), pk(0, 0, 5'h1F, 8'hAA, 8'h55, 8'hEE, 16'd0));
        check("t1_pix1",  acc_at(2), pk(0, 0, 5'h1F, 8'h99, 8'h44, 8'hDD, 16'd1));
        check("t1_end",   acc_at(3), pk(1, 1, 5'h00, 8'h00, 8'h00, 8'h00, 16'd2));

        // Same stream, never acknowledged
        do_reset();
        ack_mode = 0;
        send_zeros(32);
        send_word(32'hFFAA55EE);
        send_word(32'hFF9944DD);
        send_word(32'hFFFF_FFFF);
        idle(10);
        check("t2_held_start", 64'({valid, framing, se_frame}), 64'h6);
        check("t2_overrun", 64'(overrun), 64'd1);
        check("t2_pix_idx", 64'(pix_idx), 64'd2);

        // Reset in the middle of a word clears every output on the next edge
        send_zeros(32);
        for (int i = 31; i > 21; i--) send_bit(1'b1);
        led_clk = 1'b0;
        rst = 1'b1;
        reset_decoder();
        @(negedge clk);
        check("rst_mid_word", 64'({valid, framing, se_frame, dat_glo, dat_red, dat_grn, dat_blu,
                                   pix_idx, overrun, frame_err}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        acc.delete();

        // Extended start frame
        do_reset();
        ack_mode = 1;
        send_zeros(40);
        send_word(32'hE0123456);
        idle(10);
        check("t3_count", 64'(acc.size()), 64'd2);
        check("t3_pix", acc_at(1), pk(0, 0, 5'h00, 8'h12, 8'h34, 8'h56, 16'd0));

        // Malformed word, then recovery
        do_reset();
        send_zeros(32);
        send_word(32'hC0000001);
        idle(10);
        check("t4_frame_err", 64'(frame_err), 64'd1);
        check("t4_no_pixel", 64'(acc.size()), 64'd1);
        send_zeros(32);
        send_word(32'hE1020304);
        idle(10);
        check("t4_recover", acc_at(2), pk(0, 0, 5'h01, 8'h02, 8'h03, 8'h04, 16'd0));

        // Timeout inside a word, then recovery
        do_reset();
        send_zeros(32);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        idle(1100);
        check("t5_timeout_err", 64'(frame_err), 64'd1);
        send_zeros(32);
        send_word(32'hFE445566);
        idle(10);
        check("t5_recover", acc_at(acc.size() - 1), pk(0, 0, 5'h1E, 8'h44, 8'h55, 8'h66, 16'd0));

        // Random streams, random phase lengths and random ack
        do_reset();
        ack_mode = 2;
        ph_rand  = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int unsigned r;
            logic [31:0] w;
            r = $urandom_range(0, 9);
            w = $urandom;
            if (r < 2)       send_zeros(int'($urandom_range(32, 40)));
            else if (r < 7)  send_word(w | 32'hE000_0000);
            else if (r == 7) send_word(32'hFFFF_FFFF);
            else if (r == 8) send_word(w & 32'h7FFF_FFFF);
            else begin
                for (int j = 0; j < int'($urandom_range(1, 40)); j++) send_bit(w[j % 32]);
            end
        end
        ph_rand = 1'b0;
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
